// File: rtl/instr_mem_responder_if.sv
// Instruction fetch bus between a core fetch unit (master) and the memory responder (slave).
interface instr_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_instr;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr,
    input  rsp_ready, rsp_instr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output rsp_ready, rsp_instr, rsp_err
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: serves fetches from a word array after a base latency
// plus optional LFSR-driven extra latency, with back-to-back accepts and a preload port.
module instr_mem_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 65536,
  parameter int                    LATENCY     = 1,
  parameter int                    EXTRA_BITS  = 0,
  parameter logic [15:0]           LFSR_SEED   = 16'hACE1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE  = 32'hDEADBEEF
) (
  input  logic                           clk,
  input  logic                           rst,
  instr_mem_responder_if.slave           bus,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]          load_data,
  output logic                           busy
);

  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int HI_LSB    = IDX_W + 2;
  localparam int MAX_TOTAL = LATENCY + (1 << EXTRA_BITS) - 1;
  localparam int CNT_W     = $clog2(MAX_TOTAL + 1);
  localparam logic [15:0] EXTRA_MASK = 16'((1 << EXTRA_BITS) - 1);

  if (LATENCY < 1) begin : g_bad_latency
    $error("instr_mem_responder: LATENCY must be >= 1");
  end
  if (EXTRA_BITS < 0 || EXTRA_BITS > 16) begin : g_bad_extra
    $error("instr_mem_responder: EXTRA_BITS must be in 0..16");
  end
  if (ADDR_WIDTH < HI_LSB) begin : g_bad_addr
    $error("instr_mem_responder: ADDR_WIDTH too small for DEPTH_WORDS");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  rsp_ready_q, rsp_ready_d;
  logic [DATA_WIDTH-1:0] rsp_instr_q, rsp_instr_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  busy_q, busy_d;

  logic [CNT_W-1:0]      total;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  out_of_range;
  logic                  rd_err;

  // NOTE: the array has no reset; clearing a memory costs a reset path to every word
  // and the contents are defined by the preload port instead.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  assign total = CNT_W'(LATENCY) + CNT_W'(lfsr_q & EXTRA_MASK);

  always_ff @(posedge clk) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      rsp_ready_q <= 1'b0;
      rsp_instr_q <= FILL_VALUE;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      lfsr_q      <= lfsr_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lfsr_d  = lfsr_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          lfsr_d = lfsr_next(lfsr_q);
          if (total == CNT_W'(1)) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = total - CNT_W'(2);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!bus.req_valid)         state_d = S_IDLE;
        else if (cnt_q == '0)       state_d = S_RESP;
        else                        cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A single-cycle accept reads with the live address; a waited request uses the captured one.
  assign rd_addr = (state_q == S_WAIT) ? addr_q : bus.req_addr;

  if (ADDR_WIDTH > HI_LSB) begin : g_range
    assign out_of_range = |rd_addr[ADDR_WIDTH-1:HI_LSB];
  end else begin : g_no_range
    assign out_of_range = 1'b0;
  end

  assign rd_err = (rd_addr[1:0] != 2'b00) || out_of_range;

  // Output logic: the array read is taken on the transition into RESP
  always_comb begin
    rsp_ready_d = (state_d == S_RESP);
    rsp_err_d   = rsp_ready_d && rd_err;
    rsp_instr_d = FILL_VALUE;
    if (rsp_ready_d && !rd_err) rsp_instr_d = mem_q[rd_addr[HI_LSB-1:2]];
    busy_d      = (state_d != S_IDLE);
  end

  assign bus.rsp_ready = rsp_ready_q;
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: three instances cover LATENCY=1, LATENCY=4
// and LATENCY=2 with 2-bit random extra latency.
module tb_instr_mem_responder;

  localparam logic [31:0] FILL = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        busy_l1, busy_l4, busy_rnd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_l1  ();
  instr_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_l4  ();
  instr_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_rnd ();

  instr_mem_responder #(.DEPTH_WORDS(65536), .LATENCY(1), .EXTRA_BITS(0)) u_l1 (
    .clk(clk), .rst(rst), .bus(if_l1), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy_l1)
  );

  instr_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .EXTRA_BITS(0)) u_l4 (
    .clk(clk), .rst(rst), .bus(if_l4), .load_en(load_en), .load_addr(load_addr[9:0]),
    .load_data(load_data), .busy(busy_l4)
  );

  instr_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .EXTRA_BITS(2)) u_rnd (
    .clk(clk), .rst(rst), .bus(if_rnd), .load_en(load_en), .load_addr(load_addr[9:0]),
    .load_data(load_data), .busy(busy_rnd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = idx;
    load_data = data;
    step();
    load_en   = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Issue one request on the random-latency instance and return cycles until rsp_ready.
  task automatic timed_fetch(output int lat);
    if_rnd.req_valid = 1'b1;
    if_rnd.req_addr  = 32'h40;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!if_rnd.rsp_ready && lat < 10);
    if_rnd.req_valid = 1'b0;
    step();
  endtask

  logic [15:0] lfsr_ref;
  int          lat;
  int          exp_lat;
  logic        seen;

  initial begin
    if_l1.req_valid  = 1'b0; if_l1.req_addr  = '0;
    if_l4.req_valid  = 1'b0; if_l4.req_addr  = '0;
    if_rnd.req_valid = 1'b0; if_rnd.req_addr = '0;

    // Preload while reset is held
    rst = 1'b1;
    step();
    load(16'h10, 32'h00500093);
    load(16'h0, 32'd1);
    load(16'h1, 32'd2);
    load(16'h2, 32'd3);
    load(16'h3, 32'd4);
    check("rst_ready", {31'b0, if_l1.rsp_ready}, 32'd0);
    check("rst_instr", if_l1.rsp_instr, FILL);
    check("rst_err",   {31'b0, if_l1.rsp_err}, 32'd0);
    check("rst_busy",  {31'b0, busy_l1}, 32'd0);
    check("rst_busy_rnd", {31'b0, busy_rnd}, 32'd0);
    rst = 1'b0;
    step();

    // Single fetch, LATENCY=1
    if_l1.req_valid = 1'b1;
    if_l1.req_addr  = 32'h40;
    step();
    check("l1_ready", {31'b0, if_l1.rsp_ready}, 32'd1);
    check("l1_instr", if_l1.rsp_instr, 32'h00500093);
    check("l1_err",   {31'b0, if_l1.rsp_err}, 32'd0);
    if_l1.req_valid = 1'b0;
    step();
    check("l1_idle_ready", {31'b0, if_l1.rsp_ready}, 32'd0);
    check("l1_idle_instr", if_l1.rsp_instr, FILL);
    check("l1_idle_busy",  {31'b0, busy_l1}, 32'd0);

    // Back-to-back stream: one response per cycle, each for the prior address
    if_l1.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_l1.req_addr = 32'(4 * i);
      step();
      check("stream_ready", {31'b0, if_l1.rsp_ready}, 32'd1);
      check("stream_instr", if_l1.rsp_instr, 32'(i + 1));
    end
    if_l1.req_valid = 1'b0;
    step();
    check("stream_end", {31'b0, if_l1.rsp_ready}, 32'd0);

    // Misaligned and out-of-range addresses
    if_l1.req_valid = 1'b1;
    if_l1.req_addr  = 32'h42;
    step();
    check("mis_ready", {31'b0, if_l1.rsp_ready}, 32'd1);
    check("mis_err",   {31'b0, if_l1.rsp_err}, 32'd1);
    check("mis_instr", if_l1.rsp_instr, FILL);
    if_l1.req_addr = 32'h0004_0000;
    step();
    check("oor_err",   {31'b0, if_l1.rsp_err}, 32'd1);
    check("oor_instr", if_l1.rsp_instr, FILL);
    if_l1.req_addr = 32'h0003_FFFC;
    step();
    check("top_word_err", {31'b0, if_l1.rsp_err}, 32'd0);
    if_l1.req_valid = 1'b0;
    step();
    check("err_clear", {31'b0, if_l1.rsp_err}, 32'd0);

    // Read-before-write on a same-cycle preload of the word being fetched
    load(16'h3, 32'h11111111);
    if_l1.req_valid = 1'b1;
    if_l1.req_addr  = 32'hC;
    load_en   = 1'b1;
    load_addr = 16'h3;
    load_data = 32'hA5A5A5A5;
    step();
    load_en = 1'b0;
    check("rbw_old", if_l1.rsp_instr, 32'h11111111);
    step();
    check("rbw_new", if_l1.rsp_instr, 32'hA5A5A5A5);
    if_l1.req_valid = 1'b0;
    step();

    // LATENCY=4: response exactly four cycles after accept
    if_l4.req_valid = 1'b1;
    if_l4.req_addr  = 32'h40;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("l4_busy",  {31'b0, busy_l4}, 32'd1);
      check("l4_ready", {31'b0, if_l4.rsp_ready}, (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) begin
        check("l4_instr", if_l4.rsp_instr, 32'h00500093);
        if_l4.req_valid = 1'b0;
      end
    end
    step();
    check("l4_done_busy",  {31'b0, busy_l4}, 32'd0);
    check("l4_done_ready", {31'b0, if_l4.rsp_ready}, 32'd0);

    // LATENCY=4 abort: valid dropped in cycle 2
    if_l4.req_valid = 1'b1;
    step();
    step();
    if_l4.req_valid = 1'b0;
    step();
    check("abort_busy", {31'b0, busy_l4}, 32'd0);
    seen = 1'b0;
    repeat (6) begin
      if (if_l4.rsp_ready) seen = 1'b1;
      step();
    end
    check("abort_no_rsp", {31'b0, seen}, 32'd0);

    // Random extra latency follows the reference LFSR from the seed
    lfsr_ref = 16'hACE1;
    for (int i = 0; i < 100; i++) begin
      exp_lat  = 2 + int'(lfsr_ref[1:0]);
      lfsr_ref = lfsr_step(lfsr_ref);
      timed_fetch(lat);
      check("rnd_lat", 32'(lat), 32'(exp_lat));
    end

    // Reset mid-WAIT cancels the response and reseeds the LFSR
    if_rnd.req_valid = 1'b1;
    if_rnd.req_addr  = 32'h40;
    step();
    check("rstw_busy", {31'b0, busy_rnd}, 32'd1);
    rst = 1'b1;
    if_rnd.req_valid = 1'b0;
    step();
    rst = 1'b0;
    check("rstw_idle",  {31'b0, busy_rnd}, 32'd0);
    check("rstw_ready", {31'b0, if_rnd.rsp_ready}, 32'd0);
    step();
    check("rstw_no_rsp", {31'b0, if_rnd.rsp_ready}, 32'd0);
    timed_fetch(lat);
    check("rstw_reseed_lat", 32'(lat), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
